// File: rtl/fifo_pkg.sv
// Shared definitions for the prefetch FIFO family: defaults, a clog2 helper
// and the legal parameter envelope.
package fifo_pkg;

    localparam int unsigned DEF_AEMPTY_TH    = 4;
    localparam int unsigned DEF_AFULL_MARGIN = 4;

    localparam int unsigned MIN_DATA_WIDTH  = 1;
    localparam int unsigned MAX_DATA_WIDTH  = 1152;
    localparam int unsigned MIN_DEPTH_WIDTH = 4;
    localparam int unsigned MAX_DEPTH_WIDTH = 20;

    function automatic int unsigned fifo_clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        while ((32'd1 << res) < value) begin
            res = res + 1;
        end
        return res;
    endfunction

    function automatic bit fifo_params_ok(input int unsigned dw, input int unsigned aw,
                                          input int unsigned afull, input int unsigned aempty);
        return (dw >= MIN_DATA_WIDTH) && (dw <= MAX_DATA_WIDTH) &&
               (aw >= MIN_DEPTH_WIDTH) && (aw <= MAX_DEPTH_WIDTH) &&
               (fifo_clog2(32'd1 << aw) == aw) &&
               (afull <= (32'd1 << aw)) && (aempty <= (32'd1 << aw));
    endfunction

endpackage

// File: rtl/fifo_prefetch_sc_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
// The read register holds its value whenever re_i is low.
module fifo_prefetch_sc_ram #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 13
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/fifo_prefetch_sc.sv
// Single-clock first-word-fall-through FIFO: RAM plus a two-slot prefetch
// (RAM read register, then output register), with thresholds, flush and sticky flags.
module fifo_prefetch_sc
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned DEPTH_WIDTH = 13,
    parameter int unsigned AFULL_TH    = (32'd1 << DEPTH_WIDTH) - DEF_AFULL_MARGIN,
    parameter int unsigned AEMPTY_TH   = DEF_AEMPTY_TH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_vld,
    input  logic                  rd_en,
    output logic                  rd_vld,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [DEPTH_WIDTH:0]  word_cnt,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  ovf,
    output logic                  udf
);

    localparam int CW = DEPTH_WIDTH + 1;
    localparam logic [DEPTH_WIDTH:0] CAP      = CW'(1) << DEPTH_WIDTH;
    localparam logic [DEPTH_WIDTH:0] AFULL_V  = AFULL_TH[DEPTH_WIDTH:0];
    localparam logic [DEPTH_WIDTH:0] AEMPTY_V = AEMPTY_TH[DEPTH_WIDTH:0];

    if (!fifo_params_ok(DATA_WIDTH, DEPTH_WIDTH, AFULL_TH, AEMPTY_TH)) begin : g_param_err
        $error("fifo_prefetch_sc: parameter out of range");
    end

    logic [DEPTH_WIDTH-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [DEPTH_WIDTH:0]   cnt_q, cnt_d, pf_cnt;
    logic                   wr_vld_q, wr_vld_d;
    logic                   ram_vld_q, ram_vld_d, out_vld_q, out_vld_d;
    logic [DATA_WIDTH-1:0]  out_q, out_d, ram_rdata;
    logic                   ovf_q, ovf_d, udf_q, udf_d;
    logic                   wr_acc, rd_acc, move, fetch;

    fifo_prefetch_sc_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(DEPTH_WIDTH)
    ) u_ram (
        .clk_i  (clk),
        .we_i   (wr_acc),
        .waddr_i(wptr_q),
        .wdata_i(wr_data),
        .re_i   (fetch),
        .raddr_i(rptr_q),
        .rdata_o(ram_rdata)
    );

    // Words still in RAM = total count minus the ones sitting in the prefetch slots.
    always_comb begin
        wr_acc = wr_en & wr_vld_q & ~flush;
        rd_acc = rd_en & out_vld_q & ~flush;
        pf_cnt = CW'(ram_vld_q) + CW'(out_vld_q);
        move   = ram_vld_q & (~out_vld_q | rd_acc);
        fetch  = ~flush & (cnt_q > pf_cnt) & (~ram_vld_q | move);
    end

    always_comb begin
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        cnt_d     = cnt_q;
        wr_vld_d  = wr_vld_q;
        ram_vld_d = ram_vld_q;
        out_vld_d = out_vld_q;
        out_d     = out_q;
        ovf_d     = ovf_q;
        udf_d     = udf_q;
        if (flush) begin
            wptr_d    = '0;
            rptr_d    = '0;
            cnt_d     = '0;
            wr_vld_d  = 1'b1;
            ram_vld_d = 1'b0;
            out_vld_d = 1'b0;
            ovf_d     = 1'b0;
            udf_d     = 1'b0;
        end else begin
            if (wr_acc) wptr_d = wptr_q + DEPTH_WIDTH'(1);
            if (fetch)  rptr_d = rptr_q + DEPTH_WIDTH'(1);
            case ({wr_acc, rd_acc})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
            if (wr_en & ~wr_vld_q) ovf_d = 1'b1;
            if (rd_en & ~out_vld_q) udf_d = 1'b1;
            if (fetch) begin
                ram_vld_d = 1'b1;
            end else if (move) begin
                ram_vld_d = 1'b0;
            end
            if (move) begin
                out_vld_d = 1'b1;
                out_d     = ram_rdata;
            end else if (rd_acc) begin
                out_vld_d = 1'b0;
            end
            wr_vld_d = (cnt_d < CAP);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            cnt_q     <= '0;
            wr_vld_q  <= 1'b0;
            ram_vld_q <= 1'b0;
            out_vld_q <= 1'b0;
            out_q     <= '0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            cnt_q     <= cnt_d;
            wr_vld_q  <= wr_vld_d;
            ram_vld_q <= ram_vld_d;
            out_vld_q <= out_vld_d;
            out_q     <= out_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
        end
    end

    assign wr_vld       = wr_vld_q;
    assign rd_vld       = out_vld_q;
    assign rd_data      = out_q;
    assign word_cnt     = cnt_q;
    assign almost_full  = (cnt_q >= AFULL_V);
    assign almost_empty = (cnt_q <= AEMPTY_V);
    assign ovf          = ovf_q;
    assign udf          = udf_q;

endmodule

// File: doc/fifo_prefetch_sc.md
# fifo_prefetch_sc

Single-clock, parametrised prefetch (first-word-fall-through) FIFO for the HDMI board datapath. It replaces the fixed 8-bit × 8K prefetch FIFO core wherever producer and consumer share one clock: video line buffers, OSD/character streams and UART/I2C staging. It adds over the fixed core:
- programmable almost-full/almost-empty thresholds
- an occupancy count
- synchronous flush
- sticky overflow/underflow flags

It sustains one word per cycle in each direction.

## Interface
- DATA_WIDTH, 8: word width, 1..1152
- DEPTH_WIDTH, 13: log2 capacity, 4..20; capacity = 2^DEPTH_WIDTH words
- AFULL_TH, 2^DEPTH_WIDTH-4: almost_full when word_cnt >= AFULL_TH
- AEMPTY_TH, 4: almost_empty when word_cnt <= AEMPTY_TH

- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous reset, active-low
- flush  in  1  synchronous clear, active-high
- wr_en  in  1  write request
- wr_data  in  DATA_WIDTH  write word
- wr_vld  out  1  space available; a write is accepted on a cycle with wr_en & wr_vld
- rd_en  in  1  read acknowledge; the word is consumed on a cycle with rd_en & rd_vld
- rd_vld  out  1  rd_data holds the head word
- rd_data  out  DATA_WIDTH  head word, valid without a prior rd_en
- word_cnt  out  DEPTH_WIDTH+1  words held, including the prefetch stages
- almost_full  out  1  word_cnt >= AFULL_TH
- almost_empty  out  1  word_cnt <= AEMPTY_TH
- ovf  out  1  sticky: a write was attempted while wr_vld=0
- udf  out  1  sticky: a read was attempted while rd_vld=0

## Operation
- Storage is a simple dual-port RAM of 2^DEPTH_WIDTH words with a registered read. Its output feeds a 2-entry prefetch stage: a RAM data register and an output register with skid.
- Pointers are DEPTH_WIDTH bits and wrap modulo 2^DEPTH_WIDTH.
- word_cnt is +1 on an accepted write and −1 on an accepted read; it is unchanged when both happen.
- wr_vld = (word_cnt < 2^DEPTH_WIDTH), registered. Total capacity is exactly 2^DEPTH_WIDTH words; the prefetch stages are counted.
- The prefetch logic fetches from RAM whenever RAM is non-empty and the prefetch stage has a free slot, or a slot is being freed this cycle.
- ovf is set on wr_en & !wr_vld; the write is dropped and no state changes.
- udf is set on rd_en & !rd_vld; there is no state change.
- ovf and udf clear only on reset or flush.
- flush resets pointers, word_cnt, the prefetch stage and ovf/udf in one cycle. wr_en/rd_en in the flush cycle are ignored. Stale RAM contents are never presented.
- Reset values:
  - wr_vld=0 (goes 1 at the first edge after rst_n deasserts)
  - rd_vld=0, rd_data=0, word_cnt=0
  - almost_full=0, almost_empty=1
  - ovf=0, udf=0
- Reset mid-stream discards all contents. The first word written after release is the first word read.

## Timing
- Write-to-read latency when empty: a write accepted at edge N gives rd_vld=1 after edge N+2.
- Throughput: with the FIFO holding ≥3 words and rd_en held high, one word per cycle with no bubbles.
- word_cnt, almost_full and almost_empty update at the same edge as the accepting write or read.
- wr_vld reflects word_cnt at the start of the cycle.
- Full FIFO with wr_en & rd_en in the same cycle: the read is accepted and the write is refused (ovf set). wr_vld returns at the next edge.
- Empty FIFO with wr_en & rd_en in the same cycle: the write is accepted, the read is refused, and udf is set.
- rd_data is stable while rd_vld=1 and rd_en=0.

## Structure
- Shared package/header fifo_pkg: clog2 function, default threshold constants, parameter range checks.
- Sub-module fifo_prefetch_sc_ram: simple dual-port synchronous RAM (1 write port, 1 registered read port), inferable to DRM blocks.
- The top level holds the pointers, counter, prefetch/skid stage, flags and flush.

## Test plan
- Reset, then write 0x01..0x10 in 16 consecutive cycles with DEPTH_WIDTH=4 → rd_vld=1 two edges after the first write; wr_vld=0 after the 16th; word_cnt=16; almost_full=1; almost_empty=0.
- Full FIFO, wr_en=1 with wr_data=0xAA → ovf=1; word_cnt stays 16; 0xAA never appears on rd_data.
- Full FIFO, rd_en held 16 cycles → 0x01..0x10 back-to-back with no bubble; then rd_vld=0, word_cnt=0, almost_empty=1.
- Empty FIFO, wr_en & rd_en together with 0x55 → udf=1; 0x55 appears two edges later with rd_vld=1.
- Continuous simultaneous write/read of incrementing data for 3×2^DEPTH_WIDTH cycles → word_cnt constant, output sequence matches input, pointers wrap cleanly.
- flush while holding 7 words, then a single write of 0x77 → rd_vld=0 for two edges, then rd_data=0x77; ovf=udf=0; word_cnt=1.
